// File: rtl/sparse_dot_pe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sparse_dot_pe_pkg
//  Description : Shared defaults, FSM state encoding and helper functions for
//                the sparse dot-product processing element.
//  Revision    : 1.0  initial release
// ============================================================================
package sparse_dot_pe_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int IDX_W_DEF  = 5;
    localparam int ACC_W_DEF  = 40;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Occupancy counter width: one extra bit so "full" (count == depth) fits.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sparse_dot_pe_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sparse_fifo
//  Description : Circular-buffer FIFO with registered storage. The head entry
//                is always visible on head_o while not empty. A push on a full
//                FIFO is accepted only when a pop happens in the same cycle;
//                otherwise it is dropped and overflow_pulse_o is raised.
//  Ports       : clk, rst (sync, active-low), push_i, pop_i, wdata_i,
//                head_o, empty_o, full_o, overflow_pulse_o
//  Revision    : 1.0  initial release
// ============================================================================
module sparse_fifo
    import sparse_dot_pe_pkg::*;
#(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             overflow_pulse_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic do_pop;
    logic do_push;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // When full, a write fits only into the slot freed by a same-cycle pop.
    assign do_push = push_i && (!full_o || do_pop);
    assign overflow_pulse_o = push_i && full_o && !do_pop;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/sparse_dot_pe.sv
`default_nettype none
// ============================================================================
//  Module      : sparse_dot_pe
//  Description : Sparse dot-product PE for a systolic array. Left and upper
//                index-sorted streams are forwarded right/down with one cycle
//                latency. Mask-selected elements are buffered per side, merged
//                by index; equal indices are multiplied (pipelined) and summed.
//  Ports       : clk, rst (sync, active-low)
//                mask_conf/new_mask            : local mask load
//                *_i_le / *_i_up               : left / upper input streams
//                *_o_ri / *_o_do               : forwarded streams
//                result/result_valid           : framed dot-product output
//                busy, overflow (sticky)       : status
//  Revision    : 1.0  initial release
// ============================================================================
module sparse_dot_pe
    import sparse_dot_pe_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int IDX_W      = IDX_W_DEF,
    parameter int MASK_W     = 2**IDX_W,
    parameter int DEPTH      = 4,
    parameter int MUL_STAGES = 2,
    parameter int ACC_W      = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mask_conf,
    input  logic [MASK_W-1:0] new_mask,
    input  logic              valid_i_le,
    input  logic              last_i_le,
    input  logic [IDX_W-1:0]  index_i_le,
    input  logic [DATA_W-1:0] data_i_le,
    input  logic              valid_i_up,
    input  logic              last_i_up,
    input  logic [IDX_W-1:0]  index_i_up,
    input  logic [DATA_W-1:0] data_i_up,
    output logic              valid_o_ri,
    output logic              last_o_ri,
    output logic [IDX_W-1:0]  index_o_ri,
    output logic [DATA_W-1:0] data_o_ri,
    output logic              valid_o_do,
    output logic              last_o_do,
    output logic [IDX_W-1:0]  index_o_do,
    output logic [DATA_W-1:0] data_o_do,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    output logic              busy,
    output logic              overflow
);

    localparam int ENT_W = IDX_W + DATA_W;
    localparam int FWD_W = ENT_W + 2;
    localparam int PRD_W = 2 * DATA_W;

    // ------------------------------------------------------------------
    // Forwarding: unconditional one-cycle register per stream
    // ------------------------------------------------------------------
    logic [FWD_W-1:0] fwd_le_q;
    logic [FWD_W-1:0] fwd_up_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fwd_le_q <= '0;
            fwd_up_q <= '0;
        end else begin
            fwd_le_q <= {valid_i_le, last_i_le, index_i_le, data_i_le};
            fwd_up_q <= {valid_i_up, last_i_up, index_i_up, data_i_up};
        end
    end

    assign {valid_o_ri, last_o_ri, index_o_ri, data_o_ri} = fwd_le_q;
    assign {valid_o_do, last_o_do, index_o_do, data_o_do} = fwd_up_q;

    // ------------------------------------------------------------------
    // Local mask; same-cycle elements still see the previous value
    // ------------------------------------------------------------------
    logic [MASK_W-1:0] mask_q;

    always_ff @(posedge clk) begin
        if (!rst)           mask_q <= '0;
        else if (mask_conf) mask_q <= new_mask;
    end

    // ------------------------------------------------------------------
    // Per-side FIFOs
    // ------------------------------------------------------------------
    logic             push_le, push_up;
    logic             pop_le, pop_up;
    logic [ENT_W-1:0] head_le, head_up;
    logic             empty_le, empty_up;
    logic             full_le, full_up;
    logic             ovf_le, ovf_up;

    assign push_le = valid_i_le && mask_q[index_i_le];
    assign push_up = valid_i_up && mask_q[index_i_up];

    sparse_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_fifo_le (
        .clk              (clk),
        .rst              (rst),
        .push_i           (push_le),
        .pop_i            (pop_le),
        .wdata_i          ({index_i_le, data_i_le}),
        .head_o           (head_le),
        .empty_o          (empty_le),
        .full_o           (full_le),
        .overflow_pulse_o (ovf_le)
    );

    sparse_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_fifo_up (
        .clk              (clk),
        .rst              (rst),
        .push_i           (push_up),
        .pop_i            (pop_up),
        .wdata_i          ({index_i_up, data_i_up}),
        .head_o           (head_up),
        .empty_o          (empty_up),
        .full_o           (full_up),
        .overflow_pulse_o (ovf_up)
    );

    logic [IDX_W-1:0]  hidx_le, hidx_up;
    logic [DATA_W-1:0] hdat_le, hdat_up;

    assign {hidx_le, hdat_le} = head_le;
    assign {hidx_up, hdat_up} = head_up;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [1:0]  state_q, state_d;
    logic        seen_le_q, seen_le_d;
    logic        seen_up_q, seen_up_d;
    logic        pend_le_q, pend_le_d;
    logic        pend_up_q, pend_up_d;
    logic        mul_issue;

    logic                  last_le, last_up;
    logic [MUL_STAGES-1:0] pvld_q;

    assign last_le = valid_i_le && last_i_le;
    assign last_up = valid_i_up && last_i_up;

    // Merge: one decision per cycle, only while a vector is running
    always_comb begin
        pop_le    = 1'b0;
        pop_up    = 1'b0;
        mul_issue = 1'b0;
        if (state_q == ST_RUN) begin
            if (!empty_le && !empty_up) begin
                if (hidx_le == hidx_up) begin
                    pop_le    = 1'b1;
                    pop_up    = 1'b1;
                    mul_issue = 1'b1;
                end else if (hidx_le < hidx_up) begin
                    pop_le = 1'b1;
                end else begin
                    pop_up = 1'b1;
                end
            end else if (!empty_le && seen_up_q) begin
                pop_le = 1'b1;      // upper side exhausted: discard left
            end else if (!empty_up && seen_le_q) begin
                pop_up = 1'b1;      // left side exhausted: discard upper
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        seen_le_d = seen_le_q;
        seen_up_d = seen_up_q;
        pend_le_d = pend_le_q;
        pend_up_d = pend_up_q;
        case (state_q)
            ST_IDLE: begin
                seen_le_d = seen_le_q | last_le;
                seen_up_d = seen_up_q | last_up;
                // Elements or last flags carried over from DRAIN/DONE also
                // start a vector; they may not be followed by fresh input.
                if (valid_i_le || valid_i_up || !empty_le || !empty_up ||
                    seen_le_q || seen_up_q)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                seen_le_d = seen_le_q | last_le;
                seen_up_d = seen_up_q | last_up;
                if (seen_le_q && seen_up_q && empty_le && empty_up)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                pend_le_d = pend_le_q | last_le;
                pend_up_d = pend_up_q | last_up;
                if (pvld_q == '0)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                // Last flags of the next vector become active as IDLE begins
                seen_le_d = pend_le_q | last_le;
                seen_up_d = pend_up_q | last_up;
                pend_le_d = 1'b0;
                pend_up_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            seen_le_q <= 1'b0;
            seen_up_q <= 1'b0;
            pend_le_q <= 1'b0;
            pend_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seen_le_q <= seen_le_d;
            seen_up_q <= seen_up_d;
            pend_le_q <= pend_le_d;
            pend_up_q <= pend_up_d;
        end
    end

    // ------------------------------------------------------------------
    // Multiplier pipeline and accumulator
    // ------------------------------------------------------------------
    logic signed [PRD_W-1:0] prod_q [MUL_STAGES];
    logic signed [PRD_W-1:0] prod_now;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    assign prod_now = $signed(hdat_le) * $signed(hdat_up);
    assign prod_ext = ACC_W'(prod_q[MUL_STAGES-1]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pvld_q <= '0;
        end else begin
            pvld_q[0] <= mul_issue;
            for (int s = 1; s < MUL_STAGES; s++) pvld_q[s] <= pvld_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        prod_q[0] <= prod_now;
        for (int s = 1; s < MUL_STAGES; s++) prod_q[s] <= prod_q[s-1];
    end

    always_comb begin
        acc_d = acc_q;
        if (state_q == ST_DONE)          acc_d = '0;
        else if (pvld_q[MUL_STAGES-1])   acc_d = acc_q + prod_ext;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] result_q;
    logic             result_valid_q;
    logic             overflow_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            result_valid_q <= (state_q == ST_DONE);
            if (state_q == ST_DONE) result_q <= acc_q;
            if (ovf_le || ovf_up)   overflow_q <= 1'b1;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign overflow     = overflow_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sparse_dot_pe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_sparse_dot_pe
//  Description : Self-checking bench for sparse_dot_pe with a behavioural
//                dot-product model, forwarding model and result scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sparse_dot_pe;

    localparam int DATA_W     = 16;
    localparam int IDX_W      = 5;
    localparam int MASK_W     = 32;
    localparam int DEPTH      = 4;
    localparam int MUL_STAGES = 2;
    localparam int ACC_W      = 40;
    localparam int FWD_W      = IDX_W + DATA_W + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b0;
    logic              mask_conf = 1'b0;
    logic [MASK_W-1:0] new_mask = '0;
    logic              valid_i_le = 1'b0, last_i_le = 1'b0;
    logic [IDX_W-1:0]  index_i_le = '0;
    logic [DATA_W-1:0] data_i_le = '0;
    logic              valid_i_up = 1'b0, last_i_up = 1'b0;
    logic [IDX_W-1:0]  index_i_up = '0;
    logic [DATA_W-1:0] data_i_up = '0;
    logic              valid_o_ri, last_o_ri, valid_o_do, last_o_do;
    logic [IDX_W-1:0]  index_o_ri, index_o_do;
    logic [DATA_W-1:0] data_o_ri, data_o_do;
    logic [ACC_W-1:0]  result;
    logic              result_valid, busy, overflow;

    sparse_dot_pe #(
        .DATA_W(DATA_W), .IDX_W(IDX_W), .MASK_W(MASK_W), .DEPTH(DEPTH),
        .MUL_STAGES(MUL_STAGES), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst(rst), .mask_conf(mask_conf), .new_mask(new_mask),
        .valid_i_le(valid_i_le), .last_i_le(last_i_le),
        .index_i_le(index_i_le), .data_i_le(data_i_le),
        .valid_i_up(valid_i_up), .last_i_up(last_i_up),
        .index_i_up(index_i_up), .data_i_up(data_i_up),
        .valid_o_ri(valid_o_ri), .last_o_ri(last_o_ri),
        .index_o_ri(index_o_ri), .data_o_ri(data_o_ri),
        .valid_o_do(valid_o_do), .last_o_do(last_o_do),
        .index_o_do(index_o_do), .data_o_do(data_o_do),
        .result(result), .result_valid(result_valid),
        .busy(busy), .overflow(overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [ACC_W-1:0] val;
        bit               has_lit;
        logic [ACC_W-1:0] lit;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             e_cur;
    logic [ACC_W-1:0] hold_res = '0;
    logic [FWD_W-1:0] exp_ri = '0, exp_do = '0;
    bit               exp_ovf = 1'b0;
    bit               rst_hit = 1'b0;
    logic [MASK_W-1:0] cur_mask = '0;

    // Current vector (bench-side)
    int                      nl, nu;
    logic [IDX_W-1:0]        li[8], ui[8];
    logic signed [DATA_W-1:0] ld[8], ud[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model of what each output register must hold after this edge
    always @(posedge clk) begin
        if (!rst) begin
            exp_ri   = '0;
            exp_do   = '0;
            hold_res = '0;
            exp_ovf  = 1'b0;
            rst_hit  = 1'b1;
        end else begin
            exp_ri  = {valid_i_le, last_i_le, index_i_le, data_i_le};
            exp_do  = {valid_i_up, last_i_up, index_i_up, data_i_up};
            rst_hit = 1'b0;
        end
    end

    // Compare process
    always @(negedge clk) begin
        chk("fwd_right", 64'(FWD_W'({valid_o_ri, last_o_ri, index_o_ri, data_o_ri})), 64'(exp_ri));
        chk("fwd_down",  64'(FWD_W'({valid_o_do, last_o_do, index_o_do, data_o_do})), 64'(exp_do));
        chk("overflow", 64'(overflow), 64'(exp_ovf));
        if (rst_hit) chk("busy_after_reset", 64'(busy), 64'(0));
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL result_valid: got unexpected pulse result=%0h expected no pulse", result);
            end else begin
                e_cur = exp_q.pop_front();
                chk("result", 64'(result), 64'(e_cur.val));
                if (e_cur.has_lit) chk("result_literal", 64'(result), 64'(e_cur.lit));
                hold_res = e_cur.val;
            end
        end else begin
            chk("result_hold", 64'(result), 64'(hold_res));
        end
    end

    function automatic logic [ACC_W-1:0] model_sum();
        logic signed [ACC_W-1:0] s = '0;
        for (int a = 0; a < nl; a++)
            for (int b = 0; b < nu; b++)
                if (li[a] == ui[b] && cur_mask[li[a]])
                    s = s + ACC_W'($signed(ld[a]) * $signed(ud[b]));
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i_le = 1'b0; last_i_le = 1'b0;
        valid_i_up = 1'b0; last_i_up = 1'b0;
        index_i_le = IDX_W'($urandom); data_i_le = DATA_W'($urandom);
        index_i_up = IDX_W'($urandom); data_i_up = DATA_W'($urandom);
        mask_conf  = 1'b0;
    endtask

    task automatic set_mask(input logic [MASK_W-1:0] m);
        mask_conf = 1'b1;
        new_mask  = m;
        cur_mask  = m;
        tick();
        mask_conf = 1'b0;
        new_mask  = MASK_W'($urandom);
    endtask

    task automatic push_exp(input bit has_lit, input logic signed [ACC_W-1:0] lit);
        exp_t e;
        e.val     = model_sum();
        e.has_lit = has_lit;
        e.lit     = lit;
        exp_q.push_back(e);
    endtask

    // Drive the current vector; each side advances independently
    task automatic send_vec(input bit gaps);
        int pl = 0;
        int pu = 0;
        while (pl < nl || pu < nu) begin
            idle_inputs();
            if (pl < nl && (!gaps || $urandom_range(0, 3) != 0)) begin
                valid_i_le = 1'b1; index_i_le = li[pl]; data_i_le = ld[pl];
                last_i_le  = (pl == nl - 1);
                pl++;
            end
            if (pu < nu && (!gaps || $urandom_range(0, 3) != 0)) begin
                valid_i_up = 1'b1; index_i_up = ui[pu]; data_i_up = ud[pu];
                last_i_up  = (pu == nu - 1);
                pu++;
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic wait_done(input int budget, input string nm);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: got %0d results pending expected 0", nm, exp_q.size());
            exp_q.delete();
        end
        tick();
    endtask

    task automatic load_vec_t1();
        nl = 3; nu = 3;
        li[0] = 1; ld[0] = 3;  li[1] = 4; ld[1] = -2; li[2] = 7; ld[2] = 5;
        ui[0] = 1; ud[0] = 2;  ui[1] = 5; ud[1] = 9;  ui[2] = 7; ud[2] = 4;
    endtask

    task automatic rand_vec();
        int idx;
        nl = $urandom_range(1, 4);
        nu = $urandom_range(1, 4);
        idx = $urandom_range(0, 2);
        for (int k = 0; k < nl; k++) begin
            li[k] = IDX_W'(idx);
            ld[k] = ($urandom_range(0, 7) == 0) ? -16'sd32768 : DATA_W'($urandom);
            idx   = idx + $urandom_range(1, 3);
        end
        idx = $urandom_range(0, 2);
        for (int k = 0; k < nu; k++) begin
            ui[k] = IDX_W'(idx);
            ud[k] = ($urandom_range(0, 7) == 0) ? -16'sd32768 : DATA_W'($urandom);
            idx   = idx + $urandom_range(1, 3);
        end
    endtask

    initial begin
        logic [MASK_W-1:0] m;

        // Reset
        rst = 1'b0;
        idle_inputs();
        tick(); tick();
        rst = 1'b1;
        tick();

        // 1: all-ones mask, 3x3 vector
        set_mask('1);
        load_vec_t1();
        send_vec(1'b0);
        push_exp(1'b1, 40'sd26);
        wait_done(MUL_STAGES + 12, "t1");

        // 2: only bit 4 enabled; extra elements are masked out
        m = '0;
        m[4] = 1'b1;
        set_mask(m);
        nl = 2; nu = 2;
        li[0] = 3; ld[0] = 100; li[1] = 4; ld[1] = 10;
        ui[0] = 4; ud[0] = -7;  ui[1] = 6; ud[1] = 50;
        send_vec(1'b0);
        push_exp(1'b1, -40'sd70);
        wait_done(MUL_STAGES + 12, "t2");

        // 4: no common indices
        set_mask('1);
        nl = 2; nu = 2;
        li[0] = 0; ld[0] = 5; li[1] = 2; ld[1] = 6;
        ui[0] = 1; ud[0] = 7; ui[1] = 3; ud[1] = 8;
        send_vec(1'b0);
        push_exp(1'b1, 40'sd0);
        wait_done(MUL_STAGES + 12, "t4");

        // 3: overflow on the 5th push with the upper side idle
        nl = 6; nu = 1;
        for (int k = 0; k < 6; k++) begin
            valid_i_le = 1'b1; index_i_le = IDX_W'(k); data_i_le = DATA_W'(k + 1);
            last_i_le  = (k == 5);
            li[k] = IDX_W'(k); ld[k] = DATA_W'(k + 1);
            tick();
            if (k == 4) exp_ovf = 1'b1;
        end
        idle_inputs();
        tick(); tick();
        ui[0] = 31; ud[0] = 7;
        valid_i_up = 1'b1; last_i_up = 1'b1; index_i_up = 31; data_i_up = 7;
        tick();
        idle_inputs();
        push_exp(1'b1, 40'sd0);
        wait_done(30, "t3");

        // 5: reset with products in flight, then a clean vector
        nl = 2; nu = 2;
        li[0] = 1; ld[0] = 3; li[1] = 2; ld[1] = 4;
        ui[0] = 1; ud[0] = 5; ui[1] = 2; ud[1] = 6;
        valid_i_le = 1'b1; index_i_le = 1; data_i_le = 3;
        valid_i_up = 1'b1; index_i_up = 1; data_i_up = 5;
        tick();
        valid_i_le = 1'b1; index_i_le = 2; data_i_le = 4;
        valid_i_up = 1'b1; index_i_up = 2; data_i_up = 6;
        tick();
        idle_inputs();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick(); tick();
        set_mask('1);
        load_vec_t1();
        send_vec(1'b0);
        push_exp(1'b1, 40'sd26);
        wait_done(MUL_STAGES + 12, "t5");

        // 6: second vector arrives while the first is draining
        load_vec_t1();
        send_vec(1'b0);
        push_exp(1'b1, 40'sd26);
        repeat (4) tick();
        nl = 1; nu = 1;
        li[0] = 4; ld[0] = 10;
        ui[0] = 4; ud[0] = -7;
        send_vec(1'b0);
        push_exp(1'b1, -40'sd70);
        wait_done(40, "t6");

        // Randomized vectors with random masks and gaps
        for (int v = 0; v < 30; v++) begin
            set_mask(MASK_W'($urandom) | MASK_W'($urandom));
            rand_vec();
            send_vec(1'b1);
            push_exp(1'b0, '0);
            wait_done(40, "rand");
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
